// File: rtl/updown_timer.sv
// HH:MM:SS up/down timer with tick prescaler, count-down expiry, clamped preset load
// and edge-detected start/stop. Optional lap capture is enabled by defining LAP_EN.
module updown_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int HOUR_MAX = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        start_stop_i,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [23:0] load_time_i,
    input  logic        mode_i,
    input  logic        lap_i,
    output logic [23:0] time_bus_o,
    output logic [23:0] lap_bus_o,
    output logic        running_o,
    output logic        done_o,
    output logic        wrap_o
);

    // state   | meaning
    // ST_STOP | time held, prescaler held at 0
    // ST_RUN  | prescaler counting, time steps on each terminal count
    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [4:0]    HH_MAX   = 5'(HOUR_MAX);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [4:0]    hh_q, hh_d;
    logic [5:0]    mm_q, mm_d;
    logic [5:0]    ss_q, ss_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;
    logic          start_q;

    logic          running;
    logic          start_edge;
    logic          tick;
    logic          time_zero;
    logic          start_ignored;

    logic [4:0]    hh_up, hh_dn, ld_hh;
    logic [5:0]    mm_up, mm_dn, ld_mm;
    logic [5:0]    ss_up, ss_dn, ld_ss;
    logic          up_wrap;
    logic          dn_zero;

    logic          unused_ld_bits;

    assign running       = (state_q == ST_RUN);
    assign start_edge    = start_stop_i & ~start_q & en_i;
    assign tick          = running & (pre_q == PRE_LAST);
    assign time_zero     = (hh_q == 5'd0) && (mm_q == 6'd0) && (ss_q == 6'd0);
    assign start_ignored = mode_i & time_zero & ~running;

    assign unused_ld_bits = ^{load_time_i[23:21], load_time_i[15:14], load_time_i[7:6]};

    // Preset fields are clamped independently before being loaded.
    assign ld_ss = (load_time_i[5:0]   > 6'd59) ? 6'd59  : load_time_i[5:0];
    assign ld_mm = (load_time_i[13:8]  > 6'd59) ? 6'd59  : load_time_i[13:8];
    assign ld_hh = (load_time_i[20:16] > HH_MAX) ? HH_MAX : load_time_i[20:16];

    always_comb begin
        ss_up   = ss_q + 6'd1;
        mm_up   = mm_q;
        hh_up   = hh_q;
        up_wrap = 1'b0;
        if (ss_q >= 6'd59) begin
            ss_up = 6'd0;
            mm_up = mm_q + 6'd1;
            if (mm_q >= 6'd59) begin
                mm_up = 6'd0;
                if (hh_q >= HH_MAX) begin
                    hh_up   = 5'd0;
                    up_wrap = 1'b1;
                end else begin
                    hh_up = hh_q + 5'd1;
                end
            end
        end
    end

    // A down step from 00:00:00 (mode flipped while running) stays at zero.
    always_comb begin
        ss_dn = ss_q - 6'd1;
        mm_dn = mm_q;
        hh_dn = hh_q;
        if (ss_q == 6'd0) begin
            ss_dn = 6'd59;
            mm_dn = mm_q - 6'd1;
            if (mm_q == 6'd0) begin
                mm_dn = 6'd59;
                hh_dn = hh_q - 5'd1;
            end
        end
        if (time_zero) begin
            ss_dn = 6'd0;
            mm_dn = 6'd0;
            hh_dn = 5'd0;
        end
        dn_zero = (hh_dn == 5'd0) && (mm_dn == 6'd0) && (ss_dn == 6'd0);
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        done_d  = done_q;
        wrap_d  = 1'b0;
        if (clr_i) begin
            state_d = ST_STOP;
            pre_d   = '0;
            hh_d    = 5'd0;
            mm_d    = 6'd0;
            ss_d    = 6'd0;
            done_d  = 1'b0;
        end else if (load_i && !running) begin
            hh_d   = ld_hh;
            mm_d   = ld_mm;
            ss_d   = ld_ss;
            done_d = 1'b0;
        end else if (start_edge && !start_ignored) begin
            state_d = running ? ST_STOP : ST_RUN;
            pre_d   = '0;
            done_d  = 1'b0;
        end else if (tick) begin
            pre_d = '0;
            if (!mode_i) begin
                hh_d   = hh_up;
                mm_d   = mm_up;
                ss_d   = ss_up;
                wrap_d = up_wrap;
            end else begin
                hh_d = hh_dn;
                mm_d = mm_dn;
                ss_d = ss_dn;
                if (dn_zero) begin
                    done_d  = 1'b1;
                    state_d = ST_STOP;
                end
            end
        end else if (running) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            pre_q   <= '0;
            hh_q    <= 5'd0;
            mm_q    <= 6'd0;
            ss_q    <= 6'd0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            start_q <= start_stop_i;
        end
    end

    assign time_bus_o = {3'b000, hh_q, 2'b00, mm_q, 2'b00, ss_q};
    assign running_o  = running;
    assign done_o     = done_q;
    assign wrap_o     = wrap_q;

`ifdef LAP_EN
    logic        lap_q;
    logic        lap_edge;
    logic [23:0] lap_bus_q, lap_bus_d;

    assign lap_edge = lap_i & ~lap_q & en_i;

    // Lap captures the displayed value from before the edge; clear still wins.
    always_comb begin
        lap_bus_d = lap_bus_q;
        if (clr_i) begin
            lap_bus_d = '0;
        end else if (lap_edge) begin
            lap_bus_d = time_bus_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q     <= 1'b0;
            lap_bus_q <= '0;
        end else begin
            lap_q     <= lap_i;
            lap_bus_q <= lap_bus_d;
        end
    end

    assign lap_bus_o = lap_bus_q;
`else
    logic unused_lap;
    assign unused_lap = lap_i;
    assign lap_bus_o  = 24'h000000;
`endif

endmodule

// File: tb/tb_updown_timer.sv
// Bench for updown_timer: directed test-plan sequence plus random stimulus, checked
// every cycle against a seconds-count reference model.
module tb_updown_timer;

    localparam int TD    = 4;
    localparam int HMAX  = 23;
    localparam int MAXT  = HMAX * 3600 + 59 * 60 + 59;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        start_stop = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_time = '0;
    logic        mode = 1'b0;
    logic        lap = 1'b0;
    logic [23:0] time_bus;
    logic [23:0] lap_bus;
    logic        running;
    logic        done;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    updown_timer #(.TICK_DIV(TD), .HOUR_MAX(HMAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .start_stop_i (start_stop),
        .clr_i        (clr),
        .load_i       (load),
        .load_time_i  (load_time),
        .mode_i       (mode),
        .lap_i        (lap),
        .time_bus_o   (time_bus),
        .lap_bus_o    (lap_bus),
        .running_o    (running),
        .done_o       (done),
        .wrap_o       (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] pack(input int t);
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        h = 5'(t / 3600);
        m = 6'((t / 60) % 60);
        s = 6'(t % 60);
        return {3'b000, h, 2'b00, m, 2'b00, s};
    endfunction

    function automatic int clamp_secs(input logic [23:0] lt);
        int h, m, s;
        h = int'(lt[20:16]);
        m = int'(lt[13:8]);
        s = int'(lt[5:0]);
        if (h > HMAX) h = HMAX;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        return h * 3600 + m * 60 + s;
    endfunction

    // Reference model: time as a total seconds count, phase counts cycles since the last step.
    int          m_t;
    int          m_phase;
    bit          m_run, m_done, m_wrap, m_sq, m_lq;
    logic [23:0] m_lap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_phase = 0; m_run = 0; m_done = 0; m_wrap = 0;
            m_sq = 0; m_lq = 0; m_lap = '0;
        end else begin
            bit se, le, tk;
            se = start_stop && !m_sq && en;
            le = lap && !m_lq && en;
            m_sq = start_stop;
            m_lq = lap;
            tk = m_run && (m_phase == TD - 1);
            m_wrap = 0;
`ifdef LAP_EN
            if (le) m_lap = pack(m_t);
`endif
            if (clr) begin
                m_t = 0; m_run = 0; m_done = 0; m_phase = 0; m_lap = '0;
            end else if (load && !m_run) begin
                m_t = clamp_secs(load_time);
                m_done = 0;
            end else if (se && !(mode && m_t == 0 && !m_run)) begin
                m_run = !m_run;
                m_done = 0;
                m_phase = 0;
            end else if (tk) begin
                m_phase = 0;
                if (!mode) begin
                    if (m_t == MAXT) begin
                        m_t = 0;
                        m_wrap = 1;
                    end else begin
                        m_t = m_t + 1;
                    end
                end else begin
                    if (m_t > 0) m_t = m_t - 1;
                    if (m_t == 0) begin
                        m_done = 1;
                        m_run = 0;
                    end
                end
            end else if (m_run) begin
                m_phase = m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_time",    32'(time_bus), 32'(pack(m_t)));
        chk("model_lap",     32'(lap_bus),  32'(m_lap));
        chk("model_running", 32'(running),  32'(m_run));
        chk("model_done",    32'(done),     32'(m_done));
        chk("model_wrap",    32'(wrap),     32'(m_wrap));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic edge_start();
        start_stop = 1'b0;
        cyc(1);
        start_stop = 1'b1;
        cyc(1);
    endtask

    logic [23:0] exp_lap5;

    initial begin
`ifdef LAP_EN
        exp_lap5 = 24'h000005;
`else
        exp_lap5 = 24'h000000;
`endif
        cyc(3);
        chk("reset_time",    32'(time_bus), 32'h0);
        chk("reset_running", 32'(running),  32'h0);
        chk("reset_done",    32'(done),     32'h0);
        rst_n = 1'b1;
        en    = 1'b1;
        cyc(1);

        // up count from zero
        start_stop = 1'b1;
        cyc(1);
        chk("start_running", 32'(running), 32'h1);
        cyc(4);
        chk("up_first",  32'(time_bus), 32'h000001);
        cyc(4);
        chk("up_second", 32'(time_bus), 32'h000002);
        cyc(12);
        chk("up_fifth",  32'(time_bus), 32'h000005);

        // lap capture
        lap = 1'b1;
        cyc(1);
        chk("lap_capture", 32'(lap_bus), 32'(exp_lap5));
        cyc(8);
        chk("lap_time_adv", 32'(time_bus), 32'h000007);
        chk("lap_held",     32'(lap_bus),  32'(exp_lap5));
        lap = 1'b0;
        cyc(1);
        en  = 1'b0;
        lap = 1'b1;
        cyc(2);
        chk("lap_en_off", 32'(lap_bus), 32'(exp_lap5));
        lap = 1'b0;
        en  = 1'b1;

        // clr > load > start in one cycle while running
        start_stop = 1'b0;
        cyc(1);
        start_stop = 1'b1;
        clr        = 1'b1;
        load       = 1'b1;
        load_time  = 24'h050505;
        cyc(1);
        clr  = 1'b0;
        load = 1'b0;
        chk("prio_time",    32'(time_bus), 32'h0);
        chk("prio_running", 32'(running),  32'h0);
        chk("prio_done",    32'(done),     32'h0);
        chk("prio_lap",     32'(lap_bus),  32'h0);

        // clamp load and up wrap
        load      = 1'b1;
        load_time = 24'h1F3F3F;
        cyc(1);
        load = 1'b0;
        chk("clamp_load", 32'(time_bus), 32'h173B3B);
        edge_start();
        chk("wrap_start", 32'(running), 32'h1);
        cyc(4);
        chk("wrap_time",    32'(time_bus), 32'h000000);
        chk("wrap_pulse",   32'(wrap),     32'h1);
        chk("wrap_running", 32'(running),  32'h1);
        load      = 1'b1;
        load_time = 24'h010203;
        cyc(1);
        load = 1'b0;
        chk("wrap_one_cycle",  32'(wrap),     32'h0);
        chk("load_while_run",  32'(time_bus), 32'h000000);

        // count down to expiry
        edge_start();
        chk("stop_running", 32'(running), 32'h0);
        mode      = 1'b1;
        load      = 1'b1;
        load_time = 24'h000100;
        cyc(1);
        load = 1'b0;
        chk("down_load", 32'(time_bus), 32'h000100);
        edge_start();
        chk("down_start", 32'(running), 32'h1);
        cyc(236);
        chk("down_one", 32'(time_bus), 32'h000001);
        cyc(4);
        chk("down_zero",    32'(time_bus), 32'h000000);
        chk("down_done",    32'(done),     32'h1);
        chk("down_stopped", 32'(running),  32'h0);
        edge_start();
        chk("down_start_ignored", 32'(running), 32'h0);
        chk("down_done_sticky",   32'(done),    32'h1);

        // asynchronous reset mid-count
        mode = 1'b0;
        edge_start();
        cyc(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_time",    32'(time_bus), 32'h0);
        chk("async_rst_running", 32'(running),  32'h0);
        chk("async_rst_lap",     32'(lap_bus),  32'h0);
        cyc(2);
        start_stop = 1'b0;
        rst_n = 1'b1;
        cyc(1);

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            clr  = ($urandom_range(0, 99) < 2);
            load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    load_time = 24'($urandom);
                else
                    load_time = {18'd0, 6'($urandom_range(0, 10))};
            end
            if ($urandom_range(0, 7) == 0) start_stop = ~start_stop;
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) lap = ~lap;
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updown_timer.md
# updown_timer

Parametrised HH:MM:SS up/down timer for the clock/timer display path. It generalises the free-running stopwatch with four additions: an internal tick prescaler, count-down mode with an expiry flag, preset load with field clamping, and edge-detected start/stop sampled on the system clock. Output uses the packed display bus format, so it drops into the existing display mux unchanged.

## Interface
- TICK_DIV, 50_000_000: clk cycles per count step (≥1).
- HOUR_MAX, 23: highest hour value before wrap (≤31).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  enables start_stop and lap edge acceptance; counting is unaffected.
- start_stop  in  1  debounced level; each accepted rising edge toggles run.
- clr  in  1  synchronous clear, level.
- load  in  1  synchronous preset load, level.
- load_time  in  24  preset, bus format.
- mode  in  1  0 = count up, 1 = count down.
- lap  in  1  debounced level; rising edge captures lap (LAP_EN only).
- timeBus  out  24  {3'b0, hh[4:0], 2'b0, mm[5:0], 2'b0, ss[5:0]}.
- lapBus  out  24  captured time, same format; tied 0 without LAP_EN.
- running  out  1  run state.
- done  out  1  sticky count-down expiry flag.
- wrap  out  1  one-cycle pulse on up-count rollover.

## Operation
- Edge detect: start_q and lap_q registered copies. Edge = in & ~q.
- Prescaler: counts 0..TICK_DIV-1 while running, otherwise held at 0. tick = running & (pre == TICK_DIV-1).
- Priority per cycle: clr > load > start edge > tick.
- clr: time = 0, lapBus = 0, running = 0, done = 0, prescaler = 0.
- load: accepted only when running = 0, otherwise ignored. Each field is clamped independently: ss>59→59, mm>59→59, hh>HOUR_MAX→HOUR_MAX. Clears done.
- start edge with en = 1: toggles running and clears done.
  - Exception: mode = 1 with time == 0 ignores the edge; running stays 0.
- Up tick: ss+1. ss 59→0 carries to mm. mm 59→0 carries to hh. HOUR_MAX:59:59 → 00:00:00 with wrap = 1 for that cycle; counting continues.
- Down tick: ss−1. ss 0→59 borrows from mm. mm 0→59 borrows from hh. The tick that produces 00:00:00 also sets done = 1 and running = 0 in the same cycle.
- mode is sampled on every tick. A change while running takes effect on the next tick.
- Lap edge with en = 1: lapBus ← timeBus value present before that clock edge.

## Timing
- Reset values: timeBus = 0, lapBus = 0, running = 0, done = 0, wrap = 0, prescaler = 0, start_q = lap_q = 0.
- Start: start_stop first high at edge N → running = 1 after N → first timeBus change after edge N+TICK_DIV.
- Subsequent steps occur every TICK_DIV cycles.
- Stop: the prescaler clears, and the partial interval is discarded.
- All outputs are registered; there is no combinational input→output path.
- rst asserted mid-count returns every output to reset values immediately, independent of clk.

## Configuration
- LAP_EN defined: lap input, lap_q, and the lapBus register are present as described.
- LAP_EN undefined: lap is ignored, and lapBus is constant 24'h000000.

## Test plan
- Reset / up-count (TICK_DIV=4, HOUR_MAX=23): release rst, pulse start_stop. running = 1 the next cycle; timeBus = 0x000001 after 4 further cycles and 0x000002 after 8.
- Up wrap: load 23:59:59 (0x173B3B), start. After one tick timeBus = 0x000000 with a one-cycle wrap, and running stays 1.
- Down expiry: mode = 1, load 00:01:00, start. 59 ticks later timeBus = 0x000001. The next tick gives 0x000000, done = 1, running = 0. A further start edge is ignored.
- Clamp / load while running: load 0x1F3F3F while stopped gives timeBus = 0x173B3B. load while running leaves timeBus unchanged.
- Priority: clr, load and a start edge asserted in the same cycle while running give time = 0, running = 0 and done = 0.
- Lap (LAP_EN): with running up at 00:00:05, a lap rising edge gives lapBus = 0x000005 while timeBus keeps advancing. With en = 0, lap edges leave lapBus unchanged.
